ascon_ad_absorb: RTL and testbench

ASCON_AD_ABSORB -- requirements
Module: ascon_ad_absorb

---
 rtl/ascon_pkg.sv | 21 ++
 rtl/ascon_round.sv | 27 ++
 rtl/ascon_ad_absorb.sv | 89 ++++++++
 tb/tb_ascon_ad_absorb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon types, round constants, padding constants and helpers.
package ascon_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_AD, PERM, DONE} state_e;
   typedef logic [4:0][63:0] state_t;
   localparam logic [63:0] PAD_BIT = 64'h8000_0000_0000_0000;
   localparam logic [63:0] DOMAIN_SEP = 64'h0000_0000_0000_0001;
   localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // keep bytes 0..n-1 (byte 0 in the top bits), then append the 0x80 marker when room remains
   function automatic logic [63:0] pad_block(input logic [63:0] d, input logic [3:0] n);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[63-8*i -: 8] = (i < int'(n)) ? 8'hff : 8'h00;
      return (d & m) | ((n < 4'd8) ? PAD_BIT >> {n, 3'b000} : 64'd0);
   endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon round (constant add, 5-bit S-box, linear diffusion).
module ascon_round
   import ascon_pkg::*;
(
   input  state_t     s,
   input  logic [7:0] rc,
   output state_t     r
);
   state_t a, b;
   always_comb begin
      a = s;
      a[2] = a[2] ^ {56'd0, rc};
      a[0] = a[0] ^ a[4];
      a[4] = a[4] ^ a[3];
      a[2] = a[2] ^ a[1];
      for (int i = 0; i < 5; i++) b[i] = a[i] ^ (~a[(i+1)%5] & a[(i+2)%5]);
      b[1] = b[1] ^ b[0];
      b[0] = b[0] ^ b[4];
      b[3] = b[3] ^ b[2];
      b[2] = ~b[2];
      r[0] = b[0] ^ ror(b[0], 19) ^ ror(b[0], 28);
      r[1] = b[1] ^ ror(b[1], 61) ^ ror(b[1], 39);
      r[2] = b[2] ^ ror(b[2], 1) ^ ror(b[2], 6);
      r[3] = b[3] ^ ror(b[3], 10) ^ ror(b[3], 17);
      r[4] = b[4] ^ ror(b[4], 7) ^ ror(b[4], 41);
   end
endmodule

// File: rtl/ascon_ad_absorb.sv
// ascon_ad_absorb: absorbs associated-data blocks into an initialized Ascon state,
// one permutation round per cycle, with automatic padding and domain separation.
module ascon_ad_absorb
   import ascon_pkg::*;
#(
   parameter int PB_ROUNDS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] in_x0,
   input  logic [63:0] in_x1,
   input  logic [63:0] in_x2,
   input  logic [63:0] in_x3,
   input  logic [63:0] in_x4,
   input  logic        in_ad_present,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] ad_data,
   input  logic [3:0]  ad_bytes,
   input  logic        ad_last,
   input  logic        ad_valid,
   output logic        ad_ready,
   output logic [63:0] out_x0,
   output logic [63:0] out_x1,
   output logic [63:0] out_x2,
   output logic [63:0] out_x3,
   output logic [63:0] out_x4,
   output logic        out_valid,
   input  logic        out_ready
);
   state_e     state;
   state_t     x, rnd;
   logic [3:0] cnt;
   logic       pad_pending, last;

   ascon_round u_round (.s(x), .rc(RC[4'(12 - PB_ROUNDS) + cnt]), .r(rnd));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         x           <= '0;
         cnt         <= '0;
         pad_pending <= 1'b0;
         last        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x     <= {in_x4 ^ (in_ad_present ? 64'd0 : DOMAIN_SEP), in_x3, in_x2, in_x1, in_x0};
               state <= in_ad_present ? WAIT_AD : DONE;
            end
            WAIT_AD: if (ad_valid) begin
               x[0]        <= x[0] ^ pad_block(ad_data, ad_bytes);
               cnt         <= '0;
               last        <= ad_last;
               pad_pending <= ad_last && ad_bytes == 4'd8;
               state       <= PERM;
            end
            PERM: begin
               x   <= rnd;
               cnt <= cnt + 4'd1;
               // the final round also decides between pad block, finish or next block
               if (cnt == 4'(PB_ROUNDS - 1)) begin
                  cnt <= '0;
                  if (pad_pending) begin
                     x[0]        <= rnd[0] ^ PAD_BIT;
                     pad_pending <= 1'b0;
                  end else if (last) begin
                     x[4]  <= rnd[4] ^ DOMAIN_SEP;
                     state <= DONE;
                  end else begin
                     state <= WAIT_AD;
                  end
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = state == IDLE;
   assign ad_ready  = state == WAIT_AD;
   assign out_valid = state == DONE;
   assign out_x0    = out_valid ? x[0] : '0;
   assign out_x1    = out_valid ? x[1] : '0;
   assign out_x2    = out_valid ? x[2] : '0;
   assign out_x3    = out_valid ? x[3] : '0;
   assign out_x4    = out_valid ? x[4] : '0;
endmodule

// File: tb/tb_ascon_ad_absorb.sv
// tb_ascon_ad_absorb: randomized self-checking bench against a message-level Ascon AD model.
module tb_ascon_ad_absorb;
   localparam int PB = 6;
   typedef struct packed {logic [63:0] x0, x1, x2, x3, x4;} st_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [63:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_x3 = '0, in_x4 = '0;
   logic        in_ad_present = 1'b0, in_valid = 1'b0, in_ready;
   logic [63:0] ad_data = '0;
   logic [3:0]  ad_bytes = '0;
   logic        ad_last = 1'b0, ad_valid = 1'b0, ad_ready;
   logic [63:0] out_x0, out_x1, out_x2, out_x3, out_x4;
   logic        out_valid, out_ready = 1'b0;
   int          n_tests = 0, n_fail = 0;
   st_t         mdl;

   always #5 clk = ~clk;

   ascon_ad_absorb #(.PB_ROUNDS(PB)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
      .in_ad_present(in_ad_present), .in_valid(in_valid), .in_ready(in_ready),
      .ad_data(ad_data), .ad_bytes(ad_bytes), .ad_last(ad_last),
      .ad_valid(ad_valid), .ad_ready(ad_ready),
      .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2), .out_x3(out_x3), .out_x4(out_x4),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   function automatic logic [63:0] rotr(logic [63:0] v, int n);
      logic [127:0] d;
      d = {v, v};
      return d[n +: 64];
   endfunction

   // reference round in the form of the Ascon C implementation
   function automatic st_t round_m(st_t s, int idx);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0] c;
      c = 8'(((15 - idx) << 4) | idx);
      {x0, x1, x2, x3, x4} = s;
      x2 ^= {56'd0, c};
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
      x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
      x2 ^= rotr(x2, 1) ^ rotr(x2, 6);
      x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
      x4 ^= rotr(x4, 7) ^ rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic st_t perm(st_t s);
      for (int i = 0; i < PB; i++) s = round_m(s, 12 - PB + i);
      return s;
   endfunction

   function automatic logic [63:0] pad_m(logic [63:0] d, int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < n) r[63-8*i -: 8] = d[63-8*i -: 8];
         else if (i == n) r[63-8*i -: 8] = 8'h80;
      return r;
   endfunction

   function automatic st_t rnd_state();
      return {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(st_t s, logic ad);
      int w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      check("load_ready", 64'(in_ready), 64'd1);
      {in_x0, in_x1, in_x2, in_x3, in_x4} = s;
      in_ad_present = ad;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mdl = s;
      if (!ad) mdl.x4 ^= 64'h1;
   endtask

   task automatic send_block(logic [63:0] d, int nb, logic lst, int gap);
      int w = 0;
      repeat (gap) tick();
      check("ad_ready_pre", 64'(ad_ready), 64'd1);
      ad_data = d; ad_bytes = 4'(nb); ad_last = lst; ad_valid = 1'b1;
      tick();
      ad_valid = 1'b0;
      mdl.x0 ^= pad_m(d, nb);
      mdl = perm(mdl);
      if (lst && nb == 8) begin
         mdl.x0 ^= 64'h8000_0000_0000_0000;
         mdl = perm(mdl);
      end
      if (lst) mdl.x4 ^= 64'h1;
      while (!(ad_ready || out_valid) && w < 100) begin tick(); w++; end
      check("latency", 64'(w), 64'((lst && nb == 8) ? 2 * PB : PB));
      check("next_hs", {62'd0, ad_ready, out_valid}, lst ? 64'd1 : 64'd2);
   endtask

   task automatic collect(int hold);
      check("out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_x0", out_x0, mdl.x0);
         check("hold_x4", out_x4, mdl.x4);
      end
      check("out_x0", out_x0, mdl.x0);
      check("out_x1", out_x1, mdl.x1);
      check("out_x2", out_x2, mdl.x2);
      check("out_x3", out_x3, mdl.x3);
      check("out_x4", out_x4, mdl.x4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("in_ready_after", 64'(in_ready), 64'd1);
      check("valid_after", 64'(out_valid), 64'd0);
      check("out_zero", out_x0 | out_x1 | out_x2 | out_x3 | out_x4, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_ad_ready", 64'(ad_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_x", out_x0 | out_x1 | out_x2 | out_x3 | out_x4, 64'd0);
      rst_n = 1'b1;
      tick();
      load(rnd_state(), 1'b0);
      collect(0);
      load(rnd_state(), 1'b1);
      send_block(64'h4153_434F_4E00_0000, 5, 1'b1, 0);
      collect(0);
      load(rnd_state(), 1'b1);
      send_block({$urandom, $urandom}, 8, 1'b1, 0);
      collect(0);
      load(rnd_state(), 1'b1);
      send_block({$urandom, $urandom}, 8, 1'b0, 0);
      send_block({$urandom, $urandom}, 8, 1'b0, 0);
      send_block({$urandom, $urandom}, 3, 1'b1, 4);
      collect(10);
      load(rnd_state(), 1'b1);
      ad_data = {$urandom, $urandom}; ad_bytes = 4'd8; ad_last = 1'b0; ad_valid = 1'b1;
      tick();
      ad_valid = 1'b0;
      repeat (3) tick();
      check("mid_perm_x0", out_x0, 64'd0);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_ad_ready", 64'(ad_ready), 64'd0);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_x", out_x0 | out_x1 | out_x2 | out_x3 | out_x4, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      load(rnd_state(), 1'b0);
      collect(0);
      for (int m = 0; m < 30; m++) begin
         int nblk;
         nblk = $urandom_range(0, 3);
         load(rnd_state(), nblk != 0);
         for (int b = 0; b < nblk; b++) begin
            int nb;
            nb = (b == nblk - 1) ? $urandom_range(0, 8) : 8;
            send_block({$urandom, $urandom}, nb, b == nblk - 1, $urandom_range(0, 3));
         end
         collect($urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
